mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency SRAM between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/access_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/access_timer.sv
// Down-counter that measures the fixed SRAM access latency.
module access_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between IF and MEM; MEM has
// priority, and a streak counter forces IF through after repeated MEM wins.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LATENCY    = 3,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  import mem_arb_pkg::*;

  localparam int TW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

  state_t        state;
  logic          owner;
  logic [SW-1:0] streak;
  logic          mem_req;
  logic          streak_full;
  logic          grant_if;
  logic          grant_mem;
  logic          timer_load;
  logic          timer_dec;
  logic          timer_zero;

  assign mem_req     = mem_rd_en | mem_wr_en;
  assign streak_full = (streak == STREAK_MAX);
  // IF only wins a contended slot once MEM has used up its streak.
  assign grant_if    = if_req & (~mem_req | streak_full);
  assign grant_mem   = mem_req & ~grant_if;

  assign timer_load = (state == ST_IDLE) & (grant_if | grant_mem);
  assign timer_dec  = (state == ST_BUSY) & ~timer_zero;

  access_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (TIMER_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign freeze = ~rst & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the rdata holding registers are reset along with the control
    // state so a completion after reset never exposes stale data.
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      streak     <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_mem) begin
            owner      <= OWN_MEM;
            sram_addr  <= mem_addr;
            sram_wdata <= mem_wdata;
            sram_we    <= mem_wr_en;
            sram_en    <= 1'b1;
            state      <= ST_BUSY;
            if (!if_req)          streak <= '0;
            else if (!streak_full) streak <= streak + SW'(1);
          end else if (grant_if) begin
            owner     <= OWN_IF;
            sram_addr <= if_addr;
            sram_we   <= 1'b0;
            sram_en   <= 1'b1;
            streak    <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (timer_zero) begin
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            // sram_we still holds the latched direction of this access.
            if (!sram_we) begin
              if (owner == OWN_MEM) mem_rdata <= sram_rdata;
              else                  if_rdata  <= sram_rdata;
            end
            if (owner == OWN_MEM) mem_ready <= 1'b1;
            else                  if_ready  <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed scoreboard bench for mem_port_arbiter against a
// transaction-level reference model and a behavioural SRAM.
module tb_mem_port_arbiter;

  localparam int L   = 3;
  localparam int MAX = 4;
  localparam int TMO = 100;

  typedef struct {
    int          grant;
    int          due;
    bit          owner;   // 1 = MEM
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        freeze;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  entry_t sb[$];
  bit     served[$];

  logic [31:0] sram_mem  [0:63];
  logic [31:0] model_mem [0:63];

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .MAX_MEM_STREAK(MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .freeze     (freeze),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural SRAM: unwritten words read as addr ^ A5A5_0000.
  initial begin
    for (int i = 0; i < 64; i++) begin
      sram_mem[i]  = (32'(i) << 2) ^ 32'hA5A5_0000;
      model_mem[i] = (32'(i) << 2) ^ 32'hA5A5_0000;
    end
  end
  assign sram_rdata = sram_mem[sram_addr[7:2]];
  always @(posedge clk) if (sram_en && sram_we) sram_mem[sram_addr[7:2]] <= sram_wdata;

  // Reference model: decides, per cycle, whether a new access starts and
  // what it must return, using the arbitration rules and a busy-until time.
  int          free_at = 0;
  int          m_streak = 0;
  logic [31:0] last_mem_rd = '0;

  always @(negedge clk) begin
    entry_t e;
    bit     mreq;
    bit     pick_if;
    mreq = mem_rd_en | mem_wr_en;
    if (rst) begin
      free_at     = cyc + 1;
      m_streak    = 0;
      last_mem_rd = '0;
    end else if (cyc >= free_at && (if_req || mreq)) begin
      pick_if = if_req && (!mreq || m_streak == MAX);
      e.grant = cyc;
      e.due   = cyc + L + 1;
      e.owner = !pick_if;
      if (pick_if) begin
        e.addr   = if_addr;
        e.we     = 1'b0;
        e.wdata  = '0;
        e.data   = model_mem[if_addr[7:2]];
        m_streak = 0;
      end else begin
        e.addr  = mem_addr;
        e.we    = mem_wr_en;
        e.wdata = mem_wdata;
        if (mem_wr_en) begin
          model_mem[mem_addr[7:2]] = mem_wdata;
          e.data = last_mem_rd;
        end else begin
          e.data      = model_mem[mem_addr[7:2]];
          last_mem_rd = e.data;
        end
        m_streak = if_req ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
      end
      sb.push_back(e);
      free_at = cyc + L + 2;
    end
  end

  // Monitor: compares DUT outputs against the head of the scoreboard.
  bit rst_d = 1'b0;

  always @(negedge clk) begin
    entry_t h;
    bit     have;
    bit     exp_ifr;
    bit     exp_memr;
    bit     exp_en;
    have     = (sb.size() != 0);
    if (have) h = sb[0];
    exp_ifr  = 1'b0;
    exp_memr = 1'b0;
    exp_en   = 1'b0;
    if (have && h.due == cyc) begin
      if (h.owner) exp_memr = 1'b1;
      else         exp_ifr  = 1'b1;
    end
    if (have && cyc > h.grant && cyc <= h.grant + L) exp_en = 1'b1;

    check("if_ready", 32'(if_ready), 32'(exp_ifr));
    check("mem_ready", 32'(mem_ready), 32'(exp_memr));
    if (exp_ifr)  check("if_rdata", if_rdata, h.data);
    if (exp_memr) check("mem_rdata", mem_rdata, h.data);
    if (have && h.due == cyc) begin
      served.push_back(h.owner);
      void'(sb.pop_front());
    end

    check("sram_en", 32'(sram_en), 32'(exp_en));
    check("sram_we", 32'(sram_we), 32'(exp_en && h.we));
    if (exp_en) check("sram_addr", sram_addr, h.addr);
    if (exp_en && h.we) check("sram_wdata", sram_wdata, h.wdata);

    check("freeze", 32'(freeze),
          32'(!rst && ((if_req && !if_ready) || ((mem_rd_en || mem_wr_en) && !mem_ready))));

    if (rst_d) begin
      check("rst sram_addr", sram_addr, 32'h0);
      check("rst sram_wdata", sram_wdata, 32'h0);
      check("rst if_rdata", if_rdata, 32'h0);
      check("rst mem_rdata", mem_rdata, 32'h0);
    end
    if (rst) sb.delete();
    rst_d = rst;
  end

  task automatic if_txn(input logic [31:0] a, input int gap, output int s, output int r,
                        output logic [31:0] d);
    bit got;
    got = 1'b0;
    r   = -1;
    d   = 'x;
    repeat (gap) begin @(posedge clk); #1; end
    if_req  = 1'b1;
    if_addr = a;
    s       = cyc;
    for (int k = 0; k < TMO; k++) begin
      @(posedge clk); #1;
      if (if_ready) begin got = 1'b1; r = cyc; d = if_rdata; break; end
    end
    check("if_txn completes", 32'(got), 32'd1);
    if_req = 1'b0;
  endtask

  task automatic mem_txn(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input int gap, output int r, output logic [31:0] d);
    bit got;
    got = 1'b0;
    r   = -1;
    d   = 'x;
    repeat (gap) begin @(posedge clk); #1; end
    mem_rd_en = rd;
    mem_wr_en = wr;
    mem_addr  = a;
    mem_wdata = wd;
    for (int k = 0; k < TMO; k++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1'b1; r = cyc; d = mem_rdata; break; end
    end
    check("mem_txn completes", 32'(got), 32'd1);
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int          s, r, r2, d_cyc;
    logic [31:0] d, d2;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Lone fetch: ready L+1 cycles after the request, data from the SRAM.
    if_txn(32'h10, 2, s, r, d);
    check("t1 latency", 32'(r - s), 32'(L + 1));
    check("t1 if_rdata", d, 32'hA5A5_0010);

    // Simultaneous IF and store: MEM goes first, mem_rdata unchanged.
    fork
      if_txn(32'h44, 0, s, r, d);
      mem_txn(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, r2, d2);
    join
    check("t2 mem before if", 32'(r2 < r), 32'd1);
    check("t2 if_rdata", d, 32'hA5A5_0044);
    check("t2 mem_rdata held", d2, 32'h0);

    // Starvation guard: exactly MAX MEM accesses, then IF, then MEM again.
    pulse_reset();
    served.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) mem_txn(32'(i * 4 + 8'h80), '0, 1'b1, 1'b0, 0, r2, d2);
      end
      begin
        for (int i = 0; i < 2; i++) if_txn(32'h20, 0, s, r, d);
      end
    join
    check("t3 served count", 32'(served.size() >= 6), 32'd1);
    if (served.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("t3 owner order", 32'(served[i]), 32'(i != MAX));
    end

    // Read+write together is a write; read-back returns the written word.
    mem_txn(32'h60, 32'h1234_5678, 1'b1, 1'b1, 1, r2, d2);
    mem_txn(32'h60, '0, 1'b1, 1'b0, 0, r2, d2);
    check("t4 read-back", d2, 32'h1234_5678);

    // Reset during the second BUSY cycle, request kept high throughout.
    repeat (2) begin @(posedge clk); #1; end
    fork
      if_txn(32'h88, 0, s, r, d);
      begin
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        d_cyc = cyc;
      end
    join
    check("t5 latency after rst", 32'(r - d_cyc), 32'(L + 1));
    check("t5 if_rdata", d, 32'hA5A5_0088);

    // Address changed mid-access: the latched address is used.
    fork
      if_txn(32'h2C, 1, s, r, d);
      begin
        repeat (3) begin @(posedge clk); #1; end
        if_addr = 32'h3C;
      end
    join
    check("t6 if_rdata", d, 32'hA5A5_002C);

    // Randomized traffic from both requesters.
    fork
      begin
        for (int i = 0; i < 40; i++)
          if_txn({24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom_range(0, 3), s, r, d);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          int kind;
          kind = $urandom_range(0, 2);
          mem_txn({24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
                  kind != 1, kind != 0, $urandom_range(0, 3), r2, d2);
        end
      end
    join

    repeat (L + 4) begin @(posedge clk); #1; end
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
